// File: rtl/dbgreg_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : dbgreg_bus_master
// Brief    : Buffers the JTAG debug-register word stream and replays it as
//            address loads / post-incrementing 32-bit writes on an arbiter port.
// Revision : 1.0
// ============================================================================
module dbgreg_bus_master #(
    parameter int FIFO_AW  = 5,
    parameter int ADDR_INC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dbgreg_in,
    input  logic        dbgreg_sel,
    input  logic        dbgreg_strobe,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wen,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int          c_DEPTH    = 2 ** FIFO_AW;
    localparam logic [31:0] c_ADDR_INC = 32'(ADDR_INC);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    logic [32:0]      r_mem [c_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             r_overflow;
    state_t           r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_valid;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [32:0]      w_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_push  = dbgreg_strobe & ~w_full;
    assign w_pop   = (r_state == ST_IDLE) & ~w_empty;
    assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {dbgreg_sel, dbgreg_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (dbgreg_strobe && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        // Address words retarget the pointer without a bus cycle.
                        if (w_head[32]) begin
                            r_addr <= w_head[31:0];
                        end else begin
                            r_wdata <= w_head[31:0];
                            r_valid <= 1'b1;
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (m_ready) begin
                        r_valid <= 1'b0;
                        r_addr  <= r_addr + c_ADDR_INC;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_wen    = 4'hF;
    assign m_valid  = r_valid;
    assign overflow = r_overflow;
    assign busy     = ~w_empty | r_valid;

endmodule
`default_nettype wire
